chip8_sprite_blitter: RTL

//  Executes CHIP-8 DRW Vx,Vy,N and CLS: XORs N sprite bytes from main memory into the 64x32 monochrome framebuffer and reports pixel collision (VF).

---
 rtl/chip8_sprite_blitter_pkg.sv | 27 ++
 rtl/chip8_sprite_blitter_if.sv | 35 +++
 rtl/chip8_sprite_blitter_shift.sv | 18 +
 rtl/chip8_sprite_blitter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/chip8_sprite_blitter_pkg.sv
// Shared CHIP-8 display constants, blitter state encoding and framebuffer
// address helper.
package chip8_sprite_blitter_pkg;

    localparam int FB_COLS          = 64;
    localparam int FB_ROWS          = 32;
    localparam int FB_BYTES_PER_ROW = FB_COLS / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LRD   = 3'd2,
        ST_LWR   = 3'd3,
        ST_RRD   = 3'd4,
        ST_RWR   = 3'd5,
        ST_CLR   = 3'd6,
        ST_DONE  = 3'd7
    } blit_state_t;

    // Byte address of pixel row y, byte column xb (8 bytes per row).
    function automatic logic [9:0] fb_byte_addr(input logic [9:0] base,
                                                input logic [4:0] y,
                                                input logic [2:0] xb);
        return base + {2'b00, y, xb};
    endfunction

endpackage

// File: rtl/chip8_sprite_blitter_if.sv
// CPU command/status handshake plus sprite-memory and framebuffer port A buses
// of the sprite blitter. The blitter is the slave side of the command
// handshake and the master of both memory buses.
interface chip8_sprite_blitter_if;

    // command / status
    logic        start;
    logic        clear;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [3:0]  n_in;
    logic [11:0] i_addr;
    logic        busy;
    logic        done;
    logic        collision;
    // sprite memory (synchronous read)
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    // framebuffer port A (synchronous read, write-enable)
    logic [9:0]  fb_addr;
    logic [7:0]  fb_rdata;
    logic [7:0]  fb_wdata;
    logic        fb_we;

    modport slave (
        input  start, clear, x_in, y_in, n_in, i_addr, mem_data, fb_rdata,
        output busy, done, collision, mem_addr, fb_addr, fb_wdata, fb_we
    );

    modport master (
        output start, clear, x_in, y_in, n_in, i_addr, mem_data, fb_rdata,
        input  busy, done, collision, mem_addr, fb_addr, fb_wdata, fb_we
    );

endinterface

// File: rtl/chip8_sprite_blitter_shift.sv
// Splits one sprite byte across two framebuffer bytes for a start column
// that is not byte aligned: left_bits land in the first byte, right_bits
// in the byte to its right.
module chip8_sprite_shift (
    input  logic [7:0] spr_i,
    input  logic [2:0] shift_i,
    output logic [7:0] left_bits_o,
    output logic [7:0] right_bits_o
);

    logic [3:0] rshift;

    // shift of 0 gives rshift 8, so right_bits_o is empty for aligned sprites
    assign rshift       = 4'd8 - {1'b0, shift_i};
    assign left_bits_o  = spr_i >> shift_i;
    assign right_bits_o = spr_i << rshift;

endmodule

// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 DRW/CLS engine: XORs N sprite rows into the 64x32 framebuffer via a
// read-modify-write on RAM port A, clipping at the right and bottom edges,
// and reports pixel collision (VF). CLS zeroes all 256 framebuffer bytes.
module chip8_sprite_blitter
    import chip8_sprite_blitter_pkg::*;
#(
    parameter logic [9:0] FB_BASE = 10'h000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    chip8_sprite_blitter_if.slave  blit_if
);

    blit_state_t state_q;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [3:0]  n_q;
    logic [11:0] ptr_q;
    logic [3:0]  row_q;
    logic [7:0]  spr_q;
    logic [7:0]  idx_q;
    logic [11:0] mem_addr_q;
    logic [9:0]  fb_addr_q;
    logic        fb_we_q;
    logic        busy_q;
    logic        done_q;
    logic        collision_q;

    logic [7:0]  left_bits;
    logic [7:0]  right_bits;
    logic [7:0]  wr_mask;
    logic        draw_wr;
    logic [4:0]  row_d;
    logic [5:0]  y_cur;
    logic [5:0]  y_next;
    logic        last_row;
    logic        need_right;
    logic        hit;
    logic        unused_bits;

    chip8_sprite_shift u_shift (
        .spr_i        (spr_q),
        .shift_i      (x_q[2:0]),
        .left_bits_o  (left_bits),
        .right_bits_o (right_bits)
    );

    // row bookkeeping: y+row kept 6 bits wide so reaching row 32 is visible
    assign row_d      = {1'b0, row_q} + 5'd1;
    assign y_cur      = {1'b0, y_q} + {2'b00, row_q};
    assign y_next     = {1'b0, y_q} + {1'b0, row_d};
    assign last_row   = (row_d == {1'b0, n_q}) || (y_next == 6'd32);
    assign need_right = (x_q[2:0] != 3'd0) && (x_q[5:3] != 3'd7);

    // select the sprite bits merged in the current write state
    always_comb begin
        // NOTE: wr_mask gets a default before the branches, so every path assigns it and no latch is inferred.
        wr_mask = 8'h00;
        draw_wr = 1'b0;
        if (state_q == ST_LWR) begin
            wr_mask = left_bits;
            draw_wr = 1'b1;
        end else if (state_q == ST_RWR) begin
            wr_mask = right_bits;
            draw_wr = 1'b1;
        end
    end

    // Old framebuffer byte only arrives in the write cycle itself, so the
    // XOR merge is combinational on fb_rdata; CLR and idle states drive 00.
    assign hit              = |(blit_if.fb_rdata & wr_mask);
    assign blit_if.fb_wdata = draw_wr ? (blit_if.fb_rdata ^ wr_mask) : 8'h00;

    assign blit_if.mem_addr  = mem_addr_q;
    assign blit_if.fb_addr   = fb_addr_q;
    assign blit_if.fb_we     = fb_we_q;
    assign blit_if.busy      = busy_q;
    assign blit_if.done      = done_q;
    assign blit_if.collision = collision_q;

    // coordinates above 63/31 wrap, so the high bits are intentionally ignored
    assign unused_bits = &{1'b0, blit_if.x_in[7:6], blit_if.y_in[7:5], y_cur[5]};

    // control FSM; outputs are registered on entry to the state that owns them
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= '0;
            ptr_q       <= '0;
            row_q       <= '0;
            spr_q       <= '0;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            fb_addr_q   <= '0;
            fb_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            fb_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (blit_if.start) begin
                        x_q         <= blit_if.x_in[5:0];
                        y_q         <= blit_if.y_in[4:0];
                        n_q         <= blit_if.n_in;
                        ptr_q       <= blit_if.i_addr;
                        row_q       <= 4'd0;
                        collision_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (blit_if.n_in == 4'd0) begin
                            state_q <= ST_DONE;
                        end else begin
                            mem_addr_q <= blit_if.i_addr;
                            state_q    <= ST_FETCH;
                        end
                    end else if (blit_if.clear) begin
                        collision_q <= 1'b0;
                        busy_q      <= 1'b1;
                        idx_q       <= 8'd0;
                        fb_addr_q   <= FB_BASE;
                        fb_we_q     <= 1'b1;
                        state_q     <= ST_CLR;
                    end
                end
                ST_FETCH: begin
                    fb_addr_q <= fb_byte_addr(FB_BASE, y_cur[4:0], x_q[5:3]);
                    state_q   <= ST_LRD;
                end
                ST_LRD: begin
                    spr_q   <= blit_if.mem_data;
                    fb_we_q <= 1'b1;
                    state_q <= ST_LWR;
                end
                ST_LWR: begin
                    collision_q <= collision_q | hit;
                    if (need_right) begin
                        fb_addr_q <= fb_addr_q + 10'd1;
                        state_q   <= ST_RRD;
                    end else begin
                        row_q <= row_d[3:0];
                        if (last_row) begin
                            state_q <= ST_DONE;
                        end else begin
                            mem_addr_q <= ptr_q + 12'(row_d);
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_RRD: begin
                    fb_we_q <= 1'b1;
                    state_q <= ST_RWR;
                end
                ST_RWR: begin
                    collision_q <= collision_q | hit;
                    row_q       <= row_d[3:0];
                    if (last_row) begin
                        state_q <= ST_DONE;
                    end else begin
                        mem_addr_q <= ptr_q + 12'(row_d);
                        state_q    <= ST_FETCH;
                    end
                end
                ST_CLR: begin
                    if (idx_q == 8'hFF) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q     <= idx_q + 8'd1;
                        fb_addr_q <= FB_BASE + {2'b00, idx_q + 8'd1};
                        fb_we_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
